// File: rtl/uart_rx_if.sv
// Receive-side handshake between uart_rx and its byte consumer.
// The master drives the held byte and event pulses; the slave accepts bytes via rx_ready.
interface uart_rx_if;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data_out,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data_out,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-byte holding register, framing-error and overrun pulses.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronized line while enabled
// START | timing to mid start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first, one per bit time
// STOP  | sampling the stop bit, then load / overrun / framing error
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rxd,
  input  logic     rx_enable,
  uart_rx_if.master rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          rxd_m, rxd_s, rxd_prev;
  logic          fall;
  logic          free;
  logic          load, frame_err_n, overrun_n;

  // Synchronizer and edge history reset to the idle line level so reset never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_m    <= rxd;
      rxd_s    <= rxd_m;
      rxd_prev <= rxd_s;
    end
  end

  assign fall = rxd_prev & ~rxd_s;
  assign free = ~rx_bus.rx_valid | rx_bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    load        = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_enable && fall) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rxd_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (!rxd_s)    frame_err_n = 1'b1;
          else if (free) load        = 1'b1;
          else           overrun_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Disable aborts silently; the holding register is left alone.
    if (!rx_enable && state != IDLE) begin
      state_n     = IDLE;
      cnt_n       = '0;
      load        = 1'b0;
      frame_err_n = 1'b0;
      overrun_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_bus.rx_data_out <= 8'h00;
      rx_bus.rx_valid    <= 1'b0;
      rx_bus.frame_err   <= 1'b0;
      rx_bus.overrun     <= 1'b0;
    end else begin
      rx_bus.frame_err <= frame_err_n;
      rx_bus.overrun   <= overrun_n;
      if (load) begin
        rx_bus.rx_data_out <= shreg;
        rx_bus.rx_valid    <= 1'b1;
      end else if (rx_bus.rx_valid && rx_bus.rx_ready) begin
        rx_bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, handshake, overrun, errors, aborts.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst_n;
  logic rxd;
  logic rx_enable;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_enable (rx_enable),
    .rx_bus    (bus.master)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Observation-only monitor, sampled on the falling edge.
  int         cyc = 0;
  int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, fall_cnt = 0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] rise_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_valid <= bus.rx_valid;
    if (rst_n) begin
      if (bus.frame_err) fe_cnt <= fe_cnt + 1;
      if (bus.overrun) ov_cnt <= ov_cnt + 1;
      if (bus.frame_err && bus.overrun) both_cnt <= both_cnt + 1;
      if (!bus.rx_valid && prev_valid) fall_cnt <= fall_cnt + 1;
      if (bus.rx_valid && !prev_valid) begin
        rise_q.push_back(bus.rx_data_out);
        rise_cyc <= cyc;
      end
    end
  end

  int t_start;
  int fe0, ov0, rs0, fl0;

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; rs0 = rise_q.size(); fl0 = fall_cnt;
  endtask

  // Start bit driven at negedge n0; each bit lasts 16 cycles; line returns high at n160.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); rxd = 1'b0; t_start = cyc;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rxd = b[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk); rxd = stop;
    repeat (15) @(negedge clk);
    @(negedge clk); rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1; rx_enable = 1'b1; bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (bus.rx_data_out !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h expected 00", bus.rx_data_out); end
    vec_cnt++; if (bus.rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); end
    vec_cnt++; if (bus.frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    vec_cnt++; if (bus.overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    snap();
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    lat = rise_cyc - t_start;
    vec_cnt++; if (rise_q.size() != rs0 + 1 || lat < 149 || lat > 155) begin err_cnt++; $display("FAIL basic_latency: got %0d cycles (rises %0d) expected 149..155 (1 rise)", lat, rise_q.size() - rs0); end
    vec_cnt++; if (bus.rx_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid: got %b expected 1", bus.rx_valid); end
    vec_cnt++; if (bus.rx_data_out !== 8'hA5) begin err_cnt++; $display("FAIL basic_data: got %h expected a5", bus.rx_data_out); end
    repeat (30) @(negedge clk);
    vec_cnt++; if (bus.rx_valid !== 1'b1 || bus.rx_data_out !== 8'hA5) begin err_cnt++; $display("FAIL basic_hold: got valid %b data %h expected 1 a5", bus.rx_valid, bus.rx_data_out); end
    vec_cnt++; if (fe_cnt != fe0 || ov_cnt != ov0) begin err_cnt++; $display("FAIL basic_pulses: got fe %0d ov %0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    bus.rx_ready = 1'b1;
    @(negedge clk); bus.rx_ready = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus.rx_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_consume: got %b expected 0", bus.rx_valid); end
  endtask

  task automatic test_back_to_back();
    snap();
    bus.rx_ready = 1'b1;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    repeat (5) @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    vec_cnt++; if (rise_q.size() != rs0 + 2) begin err_cnt++; $display("FAIL b2b_count: got %0d expected 2", rise_q.size() - rs0); end
    else begin
      vec_cnt++; if (rise_q[rs0] !== 8'h3C) begin err_cnt++; $display("FAIL b2b_first: got %h expected 3c", rise_q[rs0]); end
      vec_cnt++; if (rise_q[rs0+1] !== 8'h81) begin err_cnt++; $display("FAIL b2b_second: got %h expected 81", rise_q[rs0+1]); end
    end
    vec_cnt++; if (ov_cnt != ov0 || fe_cnt != fe0) begin err_cnt++; $display("FAIL b2b_pulses: got ov %0d fe %0d expected 0 0", ov_cnt - ov0, fe_cnt - fe0); end
    vec_cnt++; if (bus.rx_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_valid: got %b expected 0", bus.rx_valid); end
  endtask

  task automatic test_overrun();
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    vec_cnt++; if (ov_cnt != ov0 + 1) begin err_cnt++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt - ov0); end
    vec_cnt++; if (bus.rx_data_out !== 8'h11 || bus.rx_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_hold: got data %h valid %b expected 11 1", bus.rx_data_out, bus.rx_valid); end
    vec_cnt++; if (fe_cnt != fe0) begin err_cnt++; $display("FAIL ovr_fe: got %0d expected 0", fe_cnt - fe0); end
    // Consumer accepts exactly in the load cycle (cycle ending at the 154th edge after n0).
    snap();
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    vec_cnt++; if (bus.rx_data_out !== 8'h22 || bus.rx_valid !== 1'b1) begin err_cnt++; $display("FAIL simul_load: got data %h valid %b expected 22 1", bus.rx_data_out, bus.rx_valid); end
    vec_cnt++; if (fall_cnt != fl0 || ov_cnt != ov0) begin err_cnt++; $display("FAIL simul_gap: got falls %0d ov %0d expected 0 0", fall_cnt - fl0, ov_cnt - ov0); end
    bus.rx_ready = 1'b1;
    @(negedge clk); bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_err();
    snap();
    send_frame(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    vec_cnt++; if (fe_cnt != fe0 + 1) begin err_cnt++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - fe0); end
    vec_cnt++; if (bus.rx_valid !== 1'b0 || rise_q.size() != rs0) begin err_cnt++; $display("FAIL ferr_valid: got %b expected 0", bus.rx_valid); end
    vec_cnt++; if (ov_cnt != ov0) begin err_cnt++; $display("FAIL ferr_ov: got %0d expected 0", ov_cnt - ov0); end
    snap();
    @(negedge clk); rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    vec_cnt++; if (fe_cnt != fe0 || ov_cnt != ov0 || rise_q.size() != rs0 || bus.rx_valid !== 1'b0) begin err_cnt++; $display("FAIL glitch: got fe %0d ov %0d rises %0d valid %b expected 0 0 0 0", fe_cnt - fe0, ov_cnt - ov0, rise_q.size() - rs0, bus.rx_valid); end
  endtask

  task automatic test_abort();
    send_frame(8'h96, 1'b1);
    repeat (2) @(negedge clk);
    vec_cnt++; if (bus.rx_data_out !== 8'h96 || bus.rx_valid !== 1'b1) begin err_cnt++; $display("FAIL abort_pre: got data %h valid %b expected 96 1", bus.rx_data_out, bus.rx_valid); end
    snap();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(negedge clk);
        repeat (50) @(negedge clk);
        rx_enable = 1'b0;
        repeat (120) @(negedge clk);
        rx_enable = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    vec_cnt++; if (bus.rx_data_out !== 8'h96 || bus.rx_valid !== 1'b1) begin err_cnt++; $display("FAIL disable_keep: got data %h valid %b expected 96 1", bus.rx_data_out, bus.rx_valid); end
    vec_cnt++; if (fe_cnt != fe0 || ov_cnt != ov0 || rise_q.size() != rs0) begin err_cnt++; $display("FAIL disable_pulses: got fe %0d ov %0d rises %0d expected 0 0 0", fe_cnt - fe0, ov_cnt - ov0, rise_q.size() - rs0); end
    snap();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(negedge clk);
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.rx_data_out !== 8'h00 || bus.rx_valid !== 1'b0) begin err_cnt++; $display("FAIL midreset: got data %h valid %b expected 00 0", bus.rx_data_out, bus.rx_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    vec_cnt++; if (bus.rx_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0 || rise_q.size() != rs0) begin err_cnt++; $display("FAIL reset_resume: got valid %b fe %0d ov %0d rises %0d expected 0 0 0 0", bus.rx_valid, fe_cnt - fe0, ov_cnt - ov0, rise_q.size() - rs0); end
    send_frame(8'hF0, 1'b1);
    repeat (2) @(negedge clk);
    vec_cnt++; if (bus.rx_data_out !== 8'hF0 || bus.rx_valid !== 1'b1) begin err_cnt++; $display("FAIL after_reset: got data %h valid %b expected f0 1", bus.rx_data_out, bus.rx_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_abort();
    vec_cnt++; if (both_cnt != 0) begin err_cnt++; $display("FAIL both_pulses: got %0d expected 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
